// File: rtl/median_sched_pkg.sv
// Shared types and default geometry for the 3x3 median pre-processing stage.
package median_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_IMG_W    = 9;
  localparam int DEF_IMG_H    = 9;
  localparam int DEF_BRAM_LAT = 1;

endpackage

// File: rtl/median_sched_delay.sv
// LAT-deep shift register carrying {valid, row, col} so that the window
// qualifier lines up with the pixel data leaving the BRAM.
module median_sched_delay #(
  parameter int LAT   = 1,
  parameter int ROW_W = 4,
  parameter int COL_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic             o_vld,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);

  localparam int DW = 1 + ROW_W + COL_W;

  logic [LAT-1:0][DW-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {i_vld, i_row, i_col};
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pipe_q <= '0;
    else          pipe_q <= pipe_d;
  end

  assign {o_vld, o_row, o_col} = pipe_q[LAT-1];

endmodule

// File: rtl/median_window_scheduler.sv
// Raster-order BRAM read sequencer that flags each complete 3x3 window as it
// reaches the median datapath, honouring downstream hold.
module median_window_scheduler
  import median_sched_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int BRAM_LAT = DEF_BRAM_LAT,
  parameter int ADDR_W   = $clog2(IMG_W*IMG_H)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_hold,
  output logic                     o_bram_en,
  output logic [ADDR_W-1:0]        o_bram_addr,
  output logic                     o_win_valid,
  output logic [$clog2(IMG_H)-1:0] o_ctr_row,
  output logic [$clog2(IMG_W)-1:0] o_ctr_col,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H-1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W-1);
  localparam logic [2:0]       DRN_LAST = 3'(BRAM_LAT-1);

  sched_state_e     state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]       drn_cnt_q, drn_cnt_d;
  logic             issue;
  logic             win_vld;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    drn_cnt_d = drn_cnt_q;
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = READ;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      READ: begin
        issue = !i_hold;
        if (issue) begin
          // Address advances incrementally; it tracks row*IMG_W+col by construction.
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            state_d   = DRAIN;
            drn_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drn_cnt_q == DRN_LAST) state_d = DONE;
        else                       drn_cnt_d = drn_cnt_q + 3'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      drn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      drn_cnt_q <= drn_cnt_d;
    end
  end

  // Reading (r,c) with r>=2, c>=2 closes the window centred one up and one left.
  assign win_vld = issue && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign win_row = row_q - ROW_W'(1);
  assign win_col = col_q - COL_W'(1);

  median_sched_delay #(
    .LAT   (BRAM_LAT),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (win_vld),
    .i_row   (win_row),
    .i_col   (win_col),
    .o_vld   (o_win_valid),
    .o_row   (o_ctr_row),
    .o_col   (o_ctr_col)
  );

  assign o_bram_en   = issue;
  assign o_bram_addr = addr_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);

endmodule
